// File: rtl/timer_scheduler_pkg.sv
// Shared constants, channel-mode type and bus-slicing helper for the timer scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_scheduler_pkg;

  localparam int NUM_CH         = 4;
  localparam int CNT_W          = 8;
  localparam int TICK_DIV_BOARD = 100000000;  // 1 Hz tick from a 100 MHz board clock
  localparam int TICK_DIV_SIM   = 4;          // short tick period for simulation

  typedef enum logic {
    ModeOneShot  = 1'b0,
    ModePeriodic = 1'b1
  } chMode_e;

  // LSB position of channel ch inside a flattened per-channel bus of width w.
  function automatic int chLsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/timer_scheduler_tick_prescaler.sv
// Free-running prescaler producing a one-cycle Tick enable every TickDiv cycles.
// Latency: Tick is registered, high the cycle after the count reaches TickDiv-1.
// Backpressure: none; runs unconditionally outside reset.
// Ports: Clk, Rst (sync, active-high), Tick (one-cycle enable out).
module tick_prescaler
  import timer_scheduler_pkg::*;
#(
  parameter int TickDiv = TICK_DIV_BOARD,
  parameter int PreW    = 27
) (
  input  logic Clk,
  input  logic Rst,
  output logic Tick
);

  localparam logic [PreW-1:0] LastCnt = PreW'(TickDiv - 1);

  logic [PreW-1:0] preCnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      preCnt <= '0;
      Tick   <= 1'b0;
    end else begin
      Tick   <= (preCnt == LastCnt);
      preCnt <= (preCnt == LastCnt) ? '0 : preCnt + PreW'(1);
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// Four countdown timers sharing one prescaler tick, loaded through a round-robin request/ack.
// Latency: grant in cycle t -> Ack/Busy (or Done for a zero load) in t+1; expiry Done one cycle after the final tick.
// Backpressure: Req is held until Ack; one grant per cycle, so waiting requesters stall until their turn.
// Ports: Clk, Rst (sync, active-high); Req/LoadVal/Periodic/Cancel per channel in;
//        Tick (prescaler enable), Ack (grant pulse), Busy (counting), Done (expiry pulse) out.
module timer_scheduler
  import timer_scheduler_pkg::*;
#(
  parameter int TickDiv = TICK_DIV_BOARD,
  parameter int PreW    = 27,
  parameter int CntW    = CNT_W
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [NUM_CH-1:0]      Req,
  input  logic [NUM_CH*CntW-1:0] LoadVal,
  input  logic [NUM_CH-1:0]      Periodic,
  input  logic [NUM_CH-1:0]      Cancel,
  output logic                   Tick,
  output logic [NUM_CH-1:0]      Ack,
  output logic [NUM_CH-1:0]      Busy,
  output logic [NUM_CH-1:0]      Done
);

  localparam int PtrW = $clog2(NUM_CH);

  logic [PtrW-1:0]   rrPtr;
  logic [PtrW-1:0]   scanIdx;
  logic [PtrW-1:0]   grantIdx;
  logic              grantVld;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant;

  tick_prescaler #(
    .TickDiv (TickDiv),
    .PreW    (PreW)
  ) uPrescaler (
    .Clk  (Clk),
    .Rst  (Rst),
    .Tick (Tick)
  );

  // Masking with Ack stops a second grant while the requester still holds Req
  // during its Ack cycle; a cancelled channel keeps its request for next cycle.
  assign eligible = Req & ~Ack & ~Cancel;

  // First eligible channel at or after the pointer. NUM_CH is a power of two,
  // so the pointer addition wraps modulo NUM_CH by itself.
  always_comb begin
    grant    = '0;
    grantIdx = rrPtr;
    grantVld = 1'b0;
    scanIdx  = rrPtr;
    for (int k = 0; k < NUM_CH; k++) begin
      scanIdx = rrPtr + PtrW'(k);
      if (!grantVld && eligible[scanIdx]) begin
        grant[scanIdx] = 1'b1;
        grantIdx       = scanIdx;
        grantVld       = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rrPtr <= '0;
      Ack   <= '0;
    end else begin
      Ack <= grant;
      if (grantVld) begin
        rrPtr <= grantIdx + PtrW'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    logic [CntW-1:0] count;
    logic [CntW-1:0] reload;
    logic [CntW-1:0] loadVal;
    chMode_e         mode;
    logic            busyR;
    logic            doneR;

    assign loadVal = LoadVal[chLsb(i, CntW) +: CntW];

    // Priority: cancel, then load, then tick. A busy channel never holds a
    // zero count, so the else branch of the tick case is the final tick.
    always_ff @(posedge Clk) begin
      if (Rst) begin
        count  <= '0;
        reload <= '0;
        mode   <= ModeOneShot;
        busyR  <= 1'b0;
        doneR  <= 1'b0;
      end else begin
        doneR <= 1'b0;
        if (Cancel[i]) begin
          busyR <= 1'b0;
        end else if (grant[i]) begin
          count  <= loadVal;
          reload <= loadVal;
          mode   <= chMode_e'(Periodic[i]);
          busyR  <= (loadVal != '0);
          doneR  <= (loadVal == '0);
        end else if (Tick && busyR) begin
          if (count > CntW'(1)) begin
            count <= count - CntW'(1);
          end else begin
            doneR <= 1'b1;
            if (mode == ModePeriodic) begin
              count <= reload;
            end else begin
              busyR <= 1'b0;
            end
          end
        end
      end
    end

    assign Busy[i] = busyR;
    assign Done[i] = doneR;
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Scoreboard bench: a reference model predicts each next-cycle output vector, a monitor compares it.
// Latency: one expectation per clock, compared on the falling edge.
// Backpressure: requesters hold Req until Ack and drop it the cycle after.
module tb_timer_scheduler;
  import timer_scheduler_pkg::*;

  localparam int TD = TICK_DIV_SIM;
  localparam int CW = CNT_W;

  logic            Clk = 1'b0;
  logic            Rst = 1'b1;
  logic [3:0]      Req = '0;
  logic [4*CW-1:0] LoadVal = '0;
  logic [3:0]      Periodic = '0;
  logic [3:0]      Cancel = '0;
  logic            Tick;
  logic [3:0]      Ack;
  logic [3:0]      Busy;
  logic [3:0]      Done;

  timer_scheduler #(
    .TickDiv (TD),
    .PreW    (3),
    .CntW    (CW)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Req      (Req),
    .LoadVal  (LoadVal),
    .Periodic (Periodic),
    .Cancel   (Cancel),
    .Tick     (Tick),
    .Ack      (Ack),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         cyc;
    logic       tick;
    logic [3:0] ack;
    logic [3:0] busy;
    logic [3:0] done;
  } exp_t;

  exp_t expQ[$];
  int   nCmp = 0;
  int   nBad = 0;

  // Reference model: remaining whole ticks per channel, cycle count since reset.
  int       mSince = 0;
  bit       mBusy[4];
  int       mRem[4];
  int       mReload[4];
  bit       mPer[4];
  bit [3:0] mAck = '0;
  int       mPtr = 0;

  // Requester state.
  bit [3:0] pend = '0;
  bit [3:0] lastAck = '0;
  int       pendLv[4];
  bit       pendPer[4];

  int firstDone0 = -1;
  int ackCyc[4];

  function automatic bit tickAt(input int c);
    return (c > 0) && (c % TD == 0);
  endfunction

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic raise(input int ch, input int lv, input bit per);
    pend[ch]    = 1'b1;
    pendLv[ch]  = lv;
    pendPer[ch] = per;
  endtask

  // Drive one cycle of inputs, advance the model, queue the next-cycle expectation.
  task automatic step(input bit rst, input logic [3:0] cancel);
    exp_t     e;
    int       g;
    int       ch;
    bit [3:0] nAck;
    bit [3:0] nDone;
    bit [3:0] curAck;
    curAck = mAck;
    Rst    = rst;
    Cancel = cancel;
    Req    = pend;
    for (int c = 0; c < 4; c++) begin
      LoadVal[c*CW +: CW] = CW'(pendLv[c]);
      Periodic[c]         = pendPer[c];
    end
    nAck  = '0;
    nDone = '0;
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        mBusy[c] = 1'b0;
        mRem[c]  = 0;
      end
      mPtr   = 0;
      mSince = 0;
    end else begin
      g = -1;
      for (int k = 0; k < 4; k++) begin
        ch = (mPtr + k) % 4;
        if (g < 0 && pend[ch] && !curAck[ch] && !cancel[ch]) g = ch;
      end
      for (int c = 0; c < 4; c++) begin
        if (cancel[c]) begin
          mBusy[c] = 1'b0;
        end else if (c == g) begin
          mRem[c]    = pendLv[c];
          mReload[c] = pendLv[c];
          mPer[c]    = pendPer[c];
          mBusy[c]   = (pendLv[c] != 0);
          if (pendLv[c] == 0) nDone[c] = 1'b1;
        end else if (tickAt(mSince) && mBusy[c]) begin
          mRem[c] = mRem[c] - 1;
          if (mRem[c] == 0) begin
            nDone[c] = 1'b1;
            if (mPer[c]) mRem[c] = mReload[c];
            else         mBusy[c] = 1'b0;
          end
        end
      end
      if (g >= 0) begin
        nAck[g] = 1'b1;
        mPtr    = (g + 1) % 4;
      end
      mSince++;
    end
    mAck   = nAck;
    e.cyc  = mSince;
    e.tick = tickAt(mSince);
    e.ack  = nAck;
    e.done = nDone;
    for (int c = 0; c < 4; c++) e.busy[c] = mBusy[c];
    lastAck = curAck;
    if (rst) pend = '0;
    else     pend = pend & ~curAck;
    @(posedge Clk);
    expQ.push_back(e);
    #1;
  endtask

  task automatic doReset();
    step(1'b1, 4'b0000);
  endtask

  // Monitor: one expected output vector per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("outputs{tick,ack,busy,done}", e.cyc,
              {19'b0, Tick, Ack, Busy, Done},
              {19'b0, e.tick, e.ack, e.busy, e.done});
        if (Done[0] && firstDone0 < 0) firstDone0 = e.cyc;
        for (int i = 0; i < 4; i++) if (Ack[i]) ackCyc[i] = e.cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] cn;
    for (int i = 0; i < 4; i++) begin
      pendLv[i]  = 0;
      pendPer[i] = 1'b0;
      mReload[i] = 0;
      mPer[i]    = 1'b0;
      ackCyc[i]  = -1;
    end
    @(posedge Clk);
    #1;

    // Idle: Tick only, every TD cycles.
    doReset();
    repeat (15) step(1'b0, 4'b0000);

    // One-shot load of 3 on ch0.
    firstDone0 = -1;
    doReset();
    for (int c = 0; c <= 16; c++) begin
      if (c == 1) raise(0, 3, 1'b0);
      step(1'b0, 4'b0000);
    end
    @(negedge Clk);
    #1;
    check("oneshot_done_cycle", 0, firstDone0, 13);

    // Periodic load of 2 on ch1, cancelled in cycle 26.
    doReset();
    for (int c = 0; c <= 35; c++) begin
      if (c == 1) raise(1, 2, 1'b1);
      step(1'b0, (c == 26) ? 4'b0010 : 4'b0000);
    end

    // All four request together: round-robin order 0,1,2,3.
    for (int i = 0; i < 4; i++) ackCyc[i] = -1;
    doReset();
    for (int c = 0; c <= 12; c++) begin
      if (c == 1) for (int i = 0; i < 4; i++) raise(i, i + 1, (i % 2) == 1);
      step(1'b0, 4'b0000);
    end
    @(negedge Clk);
    #1;
    for (int i = 0; i < 4; i++) check("arb_ack_cycle", i, ackCyc[i], i + 2);

    // Zero load, grant on a tick cycle, cancel alongside a request.
    doReset();
    for (int c = 0; c <= 20; c++) begin
      if (c == 1) raise(2, 0, 1'b0);
      if (c == 4) raise(3, 1, 1'b0);
      if (c == 6) raise(0, 2, 1'b0);
      step(1'b0, (c == 6) ? 4'b0001 : 4'b0000);
    end

    // Reset in cycle 6 while ch0 counts.
    doReset();
    for (int c = 0; c <= 6; c++) begin
      if (c == 1) raise(0, 3, 1'b0);
      step(c == 6, 4'b0000);
    end
    repeat (14) step(1'b0, 4'b0000);

    // Randomized traffic.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      cn = '0;
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && !lastAck[i] && $urandom_range(7) == 0)
          raise(i, int'($urandom_range(4)), $urandom_range(1) == 1);
        cn[i] = ($urandom_range(39) == 0);
      end
      step($urandom_range(999) == 0, cn);
    end

    @(negedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/timer_scheduler.md
Name: timer_scheduler

Overview:
- Shared 4-channel countdown timer service driven by a single internal prescaler.
- The prescaler produces a one-cycle tick enable rather than a derived clock; 1 Hz at 100 MHz by default.
- Requesters load timers through a round-robin arbitrated request/ack handshake. Each channel counts whole ticks and pulses Done on expiry.
- Sits between the board clock and the lab-level control FSMs that need second-scale delays.

Parameters:
- TickDiv, 100000000, Clk cycles per tick; must be >= 2.
- PreW, 27, prescaler counter width; must satisfy 2^PreW >= TickDiv.
- CntW, 8, per-channel countdown width.

Ports:
- Clk  in  1  system clock
- Rst  in  1  reset, synchronous, active-high
- Req  in  4  per-channel load request; held until Ack
- LoadVal  in  4*CntW  flattened load values; channel i in bits [i*CntW +: CntW]
- Periodic  in  4  per-channel mode sampled at grant: 1 = auto-reload, 0 = one-shot
- Cancel  in  4  per-channel stop; no Done is produced
- Tick  out  1  one-cycle prescaler enable
- Ack  out  4  one-cycle grant acknowledge
- Busy  out  4  channel is counting
- Done  out  4  one-cycle expiry pulse

Behaviour:
- Reset: all outputs 0, prescaler count 0, all channel counts 0, round-robin pointer 0. Reset mid-count abandons all timers with no Done.
- Prescaler:
  - Counts 0..TickDiv-1, then wraps to 0.
  - Tick is registered and is 1 in the cycle after the count equals TickDiv-1.
  - After reset release (cycle 0), Tick is high in cycles TickDiv, 2*TickDiv, and so on.
- Arbiter:
  - Eligible channel i: Req[i]=1, Ack[i]=0, Cancel[i]=0.
  - At most one grant per cycle, searched from the pointer upward mod 4.
  - After a grant, pointer = granted+1 mod 4; with no grant the pointer holds.
  - A grant in cycle t gives Ack[i]=1 in cycle t+1 only.
  - The requester must drop Req in cycle t+2. The Ack mask prevents a double grant in t+1.
- Load, for a grant in cycle t:
  - Count := LoadVal and Reload := LoadVal.
  - Mode := Periodic[i].
  - Busy[i]=1 from cycle t+1.
  - A grant to a Busy channel restarts it.
  - LoadVal = 0: Busy stays 0; Done[i]=1 in t+1 together with Ack.
  - Grant and Tick in the same cycle on the same channel: the load wins and that tick is ignored for the channel.
- Countdown, on a cycle with Tick=1 for each Busy channel:
  - Count > 1: decrement.
  - Count = 1: Done[i]=1 in the next cycle.
    - One-shot: Busy cleared in that same next cycle.
    - Periodic: Count := Reload and Busy stays 1.
- Cancel[i] in cycle t:
  - Busy[i]=0 in t+1; any expiry in t is suppressed.
  - Cancel beats a grant and a tick in the same cycle.
  - The channel is not arbitrated in t; its Req stays pending for the next cycle.
- Channels are independent: several Done bits may pulse in the same cycle.

Decomposition:
- Shared package holds:
  - NUM_CH = 4
  - CntW default
  - TickDiv defaults: 100000000 for board, 4 for simulation
  - The channel-slice helper.
- Natural sub-module: tick_prescaler (TickDiv, PreW; ports Clk, Rst, Tick).
- The arbiter and the four channel counters stay in timer_scheduler, with the channel counters in a generate loop.

Test Plan:
- TickDiv=4, no requests after reset release at cycle 0 -> Tick high exactly in cycles 4, 8, 12; all other outputs 0.
- One-shot:
  - Stimulus: Req[0]=1, LoadVal0=3, Periodic0=0 in cycle 1.
  - Expected: Ack[0] in cycle 2; Busy[0] in cycles 2..12.
  - Expected: Done[0] in cycle 13 only; Busy[0]=0 from cycle 13.
- Periodic:
  - Stimulus: LoadVal1=2, Periodic1=1, granted cycle 1.
  - Expected: Done[1] in cycles 9, 17, 25; Busy[1] remains 1.
  - Then Cancel[1] in cycle 26 -> Busy[1]=0 in cycle 27; no Done in cycle 33.
- Arbitration:
  - Stimulus: Req=4'b1111 in cycle 1, each requester dropping Req the cycle after its Ack.
  - Expected: Ack pulses for ch0, ch1, ch2, ch3 in cycles 2, 3, 4, 5; pointer returns to 0.
- Boundary cases:
  - LoadVal=0 -> Ack and Done in the same cycle, Busy never set.
  - Grant coinciding with a Tick cycle -> that tick is not counted.
  - Cancel coinciding with Req -> no Ack in the next cycle; Ack the cycle after.
- Reset in cycle 6 with ch0 Busy -> all outputs 0 in cycle 7, no Done; Tick next appears in cycle 11.
